sobel_stage: RTL and testbench
==============================

SOBEL_STAGE -- requirements
Module: sobel_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 720, image width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 540, image height in pixels.
REQ-003 SHALL have parameter DWIDTH, default 8, pixel width in bits.
REQ-004 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_dout  input  DWIDTH  grayscale pixel at the head of the upstream first-word-fall-through FIFO, raster order.
REQ-007 SHALL have port in_empty  input  1  upstream FIFO empty.
REQ-008 SHALL have port in_rd_en  output  1  pop upstream FIFO this cycle.
REQ-009 SHALL have port out_din  output  DWIDTH  Sobel magnitude to the downstream FIFO.
REQ-010 SHALL have port out_full  input  1  downstream FIFO full.
REQ-011 SHALL have port out_wr_en  output  1  push out_din this cycle.

Function
REQ-012 SHALL assert in_rd_en only when in_empty=0 and the block can accept a pixel; a pixel is consumed exactly on a cycle with in_rd_en=1.
REQ-013 SHALL hold an output register (out_din, out_valid); out_wr_en = out_valid AND NOT out_full, combinational.
REQ-014 SHALL treat the output register as free when out_valid=0 or out_wr_en=1.
REQ-015 SHALL implement states S_PRIME, S_RUN, S_FLUSH.
REQ-016 S_PRIME: consume pixels without producing output; after WIDTH+1 pixels consumed, go to S_RUN.
REQ-017 S_RUN: pop only when in_empty=0 and the output register is free; each pop at raster index n loads the output register with the result for centre index n-WIDTH-1, visible on out_din the next cycle.
REQ-018 S_RUN: after the last pixel (index WIDTH*HEIGHT-1) is consumed, go to S_FLUSH.
REQ-019 S_FLUSH: never pop; shift a zero pixel into the window each cycle the output register is free.
REQ-020 S_FLUSH: produce the remaining WIDTH+1 results, then return to S_PRIME with all counters cleared for the next frame.
REQ-021 SHALL produce exactly WIDTH*HEIGHT outputs per frame, in raster order.
REQ-022 SHALL output 0 for every centre with row 0, row HEIGHT-1, column 0 or column WIDTH-1.
REQ-023 For other centres, SHALL use the window p[r][c] (r,c in 0..2, row 0 oldest) and compute Gx = (p02+2p12+p22)-(p00+2p10+p20).
REQ-024 SHALL compute Gy = (p20+2p21+p22)-(p00+2p01+p02).
REQ-025 SHALL compute Gx and Gy as signed 11-bit values and the sum |Gx|+|Gy| at 12 bits.
REQ-026 SHALL saturate the sum to 255, with no wrap.
REQ-027 SHALL hold all state (in_rd_en=0, out_din and out_valid unchanged) when in_empty=1 in S_PRIME or S_RUN.
REQ-028 SHALL hold all state (no pop, no shift) when out_full=1 and out_valid=1.
REQ-029 SHALL track the column counter 0..WIDTH-1 wrapping to 0 and incrementing row.
REQ-030 SHALL track the row counter 0..HEIGHT-1, cleared at frame end.

Reset
REQ-031 On reset=0, SHALL immediately set state=S_PRIME, counters=0, out_valid=0, out_din=0, in_rd_en=0, out_wr_en=0.
REQ-032 SHALL not reset line-buffer or window contents; a reset mid-frame discards the partial frame, and the next pixel consumed is treated as index 0.

Structure
REQ-033 Package sobel_pkg SHALL hold the state enumeration, default WIDTH/HEIGHT/DWIDTH, and the saturation limit 255.
REQ-034 SHALL instantiate sub-module line_buffer (DWIDTH wide, WIDTH deep shift memory, enable input) twice, chained, to supply rows 0 and 1 of the window.

Verification (bench uses WIDTH=8, HEIGHT=6)
REQ-035 Constant 100 image, no stalls -> 48 outputs, all 0; first out_wr_en one cycle after the 10th pop.
REQ-036 Pixel=0 for column<4, 255 for column>=4 -> output 255 at columns 3 and 4 of rows 1..4, 0 elsewhere.
REQ-037 Checkerboard 0/255 -> every interior output 255 (saturation), borders 0.
REQ-038 Hold out_full=1 for 20 cycles mid-S_RUN with in_empty=0 -> in_rd_en=0 and out_din stable throughout; output stream identical to the unstalled run.
REQ-039 in_empty=1 every other cycle -> output stream identical to REQ-036; no pop while in_empty=1.
REQ-040 reset=0 after 20 pixels, then a full fresh frame -> outputs go to 0 immediately; exactly 48 outputs follow, matching REQ-036.

Source files
------------

// File: rtl/sobel_pkg.sv
// sobel_pkg: shared defaults, state encoding and saturation limit for the Sobel stage.
// No ports; imported by sobel_stage and line_buffer.
package sobel_pkg;
   localparam int DEF_WIDTH  = 720;
   localparam int DEF_HEIGHT = 540;
   localparam int DEF_DWIDTH = 8;
   localparam int SAT_MAX    = 255;
   typedef enum logic [1:0] {S_PRIME, S_RUN, S_FLUSH} state_t;
endpackage

// File: rtl/line_buffer.sv
// line_buffer: DEPTH-deep shift memory delaying a pixel stream by one image line.
// Ports: clock (rising edge), en (shift one pixel in), din (pixel in), dout (pixel shifted in DEPTH enables ago).
module line_buffer import sobel_pkg::*; #(
   parameter int DWIDTH = DEF_DWIDTH,
   parameter int DEPTH  = DEF_WIDTH
) (
   input  logic              clock,
   input  logic              en,
   input  logic [DWIDTH-1:0] din,
   output logic [DWIDTH-1:0] dout
);
   logic [DWIDTH-1:0] mem [DEPTH];
   always_ff @(posedge clock)
      if (en) begin
         mem[0] <= din;
         for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
      end
   assign dout = mem[DEPTH-1];
endmodule

// File: rtl/sobel_stage.sv
// sobel_stage: streaming 3x3 Sobel magnitude between two FWFT FIFOs, one result per consumed pixel.
// Ports: clock, reset (async active-low); in_dout/in_empty/in_rd_en (upstream FIFO);
//        out_din/out_full/out_wr_en (downstream FIFO).
module sobel_stage import sobel_pkg::*; #(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int HEIGHT = DEF_HEIGHT,
   parameter int DWIDTH = DEF_DWIDTH
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DWIDTH-1:0] in_dout,
   input  logic              in_empty,
   output logic              in_rd_en,
   output logic [DWIDTH-1:0] out_din,
   input  logic              out_full,
   output logic              out_wr_en
);
   localparam int CW = WIDTH  > 1 ? $clog2(WIDTH)  : 1;
   localparam int RW = HEIGHT > 1 ? $clog2(HEIGHT) : 1;
   localparam int PW = $clog2(WIDTH + 1);
   localparam int GW = DWIDTH + 3;
   localparam int SW = DWIDTH + 4;

   state_t            state;
   logic [CW-1:0]     col;
   logic [RW-1:0]     row;
   logic [PW-1:0]     pcnt;
   logic              out_valid;
   logic [DWIDTH-1:0] a [3];
   logic [DWIDTH-1:0] b [3];
   logic [DWIDTH-1:0] top, mid, px, res;
   logic [GW-1:0]     gx, gy, ax, ay;
   logic [SW-1:0]     mag;
   logic              free, pop, shift, produce, border, wrap;

   // Nothing moves while reset is held, so in_rd_en is forced low immediately.
   assign free      = !out_valid || !out_full;
   assign pop       = reset && free && !in_empty && state != S_FLUSH;
   assign shift     = pop || (reset && free && state == S_FLUSH);
   assign produce   = shift && state != S_PRIME;
   assign px        = state == S_FLUSH ? '0 : in_dout;
   assign in_rd_en  = pop;
   assign out_wr_en = out_valid && !out_full;

   // lb_mid delays by one line (window row 1); lb_top by two lines (window row 0).
   line_buffer #(.DWIDTH(DWIDTH), .DEPTH(WIDTH)) lb_mid (.clock(clock), .en(shift), .din(px),  .dout(mid));
   line_buffer #(.DWIDTH(DWIDTH), .DEPTH(WIDTH)) lb_top (.clock(clock), .en(shift), .din(mid), .dout(top));

   // Kernel runs on the window as it will be after this shift:
   // column 0 = a, column 1 = b, column 2 = {top, mid, px}.
   always_comb begin
      gx     = GW'(top) + GW'({mid, 1'b0}) + GW'(px) - GW'(a[0]) - GW'({a[1], 1'b0}) - GW'(a[2]);
      gy     = GW'(a[2]) + GW'({b[2], 1'b0}) + GW'(px) - GW'(a[0]) - GW'({b[0], 1'b0}) - GW'(top);
      ax     = gx[GW-1] ? -gx : gx;
      ay     = gy[GW-1] ? -gy : gy;
      mag    = SW'(ax) + SW'(ay);
      border = row == '0 || row == RW'(HEIGHT-1) || col == '0 || col == CW'(WIDTH-1);
      res    = border ? '0 : mag > SW'(SAT_MAX) ? DWIDTH'(SAT_MAX) : mag[DWIDTH-1:0];
      wrap   = col == CW'(WIDTH-1);
   end

   // Window contents are deliberately left unreset; borders mask any stale data.
   always_ff @(posedge clock)
      if (shift) begin
         a <= b;
         b <= '{top, mid, px};
      end

   // row/col track the centre of the next result to be produced.
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         state     <= S_PRIME;
         col       <= '0;
         row       <= '0;
         pcnt      <= '0;
         out_valid <= 1'b0;
         out_din   <= '0;
      end else begin
         if (free) out_valid <= produce;
         if (produce) begin
            out_din <= res;
            col     <= wrap ? '0 : col + 1'b1;
            if (wrap) row <= row == RW'(HEIGHT-1) ? '0 : row + 1'b1;
         end
         case (state)
            S_PRIME:
               if (pop) begin
                  pcnt <= pcnt == PW'(WIDTH) ? '0 : pcnt + 1'b1;
                  if (pcnt == PW'(WIDTH)) state <= S_RUN;
               end
            S_RUN:
               if (pop && row == RW'(HEIGHT-2) && col == CW'(WIDTH-2)) state <= S_FLUSH;
            S_FLUSH:
               if (shift && row == RW'(HEIGHT-1) && wrap) state <= S_PRIME;
            default: state <= S_PRIME;
         endcase
      end
endmodule

// File: tb/tb_sobel_stage.sv
// tb_sobel_stage: table-driven frame checks plus stall and mid-frame reset sequences for sobel_stage.
module tb_sobel_stage;
   localparam int W = 8;
   localparam int H = 6;
   localparam int N = W * H;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] in_dout = '0;
   logic       in_empty = 1'b0;
   logic       in_rd_en;
   logic [7:0] out_din;
   logic       out_full = 1'b0;
   logic       out_wr_en;

   int passed = 0;
   int total  = 0;

   sobel_stage #(.WIDTH(W), .HEIGHT(H), .DWIDTH(8)) dut (
      .clock(clock), .reset(reset), .in_dout(in_dout), .in_empty(in_empty), .in_rd_en(in_rd_en),
      .out_din(out_din), .out_full(out_full), .out_wr_en(out_wr_en)
   );

   always #5 clock = ~clock;

   // kind: 0 constant 100, 1 step at column 4, 2 checkerboard of 2x2 tiles, 3 descending ramp.
   // Interior outputs equal exp_int where mask has the column bit set, 0 otherwise;
   // rows 0 and H-1 are always 0.
   typedef struct {
      int kind;
      bit gap;
      bit stall;
      bit lat;
      int mask;
      int exp_int;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic logic [7:0] pix(input int kind, input int r, input int c);
      case (kind)
         0:       return 8'd100;
         1:       return c < 4 ? 8'd0 : 8'd255;
         2:       return (((r >> 1) + (c >> 1)) % 2) != 0 ? 8'd255 : 8'd0;
         default: return 8'(200 - 10 * c - 20 * r);
      endcase
   endfunction

   function automatic int expect_at(input int idx, input int mask, input int exp_int);
      int r = idx / W;
      int c = idx % W;
      return (r >= 1 && r <= H - 2 && mask[c]) ? exp_int : 0;
   endfunction

   task automatic run_frame(input int tag, input vec_t v, input int abort_at);
      int ptr = 0, outs = 0, cyc = 0, idle = 0;
      int bad_pop = 0, stall_left = 0, stall_bad = 0, first_wr = -1, pop10 = -1;
      bit stalled = 0;
      logic [7:0] held = '0;
      while (cyc < 3000 && idle < 16) begin
         @(posedge clock);
         #1;
         cyc++;
         if (v.stall && !stalled && outs == 20) begin
            stalled    = 1;
            stall_left = 20;
            held       = out_din;
         end
         out_full = stall_left > 0;
         in_empty = ptr >= N || (v.gap && (cyc % 2) == 1);
         in_dout  = ptr < N ? pix(v.kind, ptr / W, ptr % W) : 8'd0;
         @(negedge clock);
         if (in_rd_en && in_empty) bad_pop++;
         if (stall_left > 0) begin
            if (in_rd_en || out_wr_en || out_din != held) stall_bad++;
            stall_left--;
         end
         if (out_wr_en) begin
            if (first_wr < 0) first_wr = cyc;
            if (outs < N) chk($sformatf("v%0d out[%0d]", tag, outs), int'(out_din), expect_at(outs, v.mask, v.exp_int));
            outs++;
         end
         if (in_rd_en) begin
            ptr++;
            if (ptr == 10) pop10 = cyc;
         end
         if (abort_at > 0 && ptr == abort_at) return;
         if (ptr == N && outs >= N) idle++;
      end
      chk($sformatf("v%0d output_count", tag), outs, N);
      chk($sformatf("v%0d pop_on_empty", tag), bad_pop, 0);
      if (v.stall) begin
         chk($sformatf("v%0d stall_seen", tag), int'(stalled), 1);
         chk($sformatf("v%0d stall_hold", tag), stall_bad, 0);
      end
      if (v.lat) chk($sformatf("v%0d first_wr_latency", tag), first_wr - pop10, 1);
      out_full = 1'b0;
   endtask

   initial begin
      vecs[0] = '{0, 1'b0, 1'b0, 1'b1, 'h00, 0};
      vecs[1] = '{1, 1'b0, 1'b0, 1'b0, 'h18, 255};
      vecs[2] = '{2, 1'b0, 1'b0, 1'b0, 'h7E, 255};
      vecs[3] = '{3, 1'b0, 1'b0, 1'b0, 'h7E, 240};
      vecs[4] = '{1, 1'b0, 1'b1, 1'b0, 'h18, 255};
      vecs[5] = '{1, 1'b1, 1'b0, 1'b0, 'h18, 255};
      vecs[6] = '{3, 1'b1, 1'b0, 1'b0, 'h7E, 240};

      // Reset held with pixels available: nothing may be popped or pushed.
      #23;
      chk("reset in_rd_en", int'(in_rd_en), 0);
      chk("reset out_wr_en", int'(out_wr_en), 0);
      chk("reset out_din", int'(out_din), 0);
      in_empty = 1'b1;
      @(negedge clock);
      reset = 1'b1;

      foreach (vecs[i]) run_frame(i, vecs[i], 0);

      // Abort a step frame after 20 pops; outputs must drop at once, then a fresh frame runs clean.
      run_frame(7, vecs[1], 20);
      in_empty = 1'b0;
      out_full = 1'b0;
      #1;
      chk("pre_abort out_wr_en", int'(out_wr_en), 1);
      reset = 1'b0;
      #1;
      chk("abort in_rd_en", int'(in_rd_en), 0);
      chk("abort out_wr_en", int'(out_wr_en), 0);
      chk("abort out_din", int'(out_din), 0);
      in_empty = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      run_frame(8, vecs[1], 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
